codec_init_sequencer: RTL and testbench
=======================================

# codec_init_sequencer

Sequences the power-up configuration of the WM8731 audio codec on the DE10-Standard. It walks a fixed 11-entry register table and hands each 16-bit control word to the I2C write master through a request/ready handshake. Failed transfers are retried after a NACK or timeout. Once the whole table is written, it raises `audio_enable` to release the digital audio interface (DAC data/LRCK generator).

## Interface
- `STARTUP_DELAY`, 1024: cycles to wait after reset before the first write.
- `RETRY_GAP`, 256: idle cycles between a failed write and its retry.
- `MAX_RETRY`, 3: retries allowed per entry; the next failure enters FAIL.
- `TIMEOUT`, 4096: cycles allowed from acceptance to `i2c_done` before the transfer counts as failed.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle re-initialisation request, honoured only in DONE or FAIL.
- `i2c_req` out 1: write request to the I2C master.
- `i2c_word` out 16: control word {reg_addr[6:0], reg_data[8:0]}.
- `i2c_dev_addr` out 8: constant 8'h34 (WM8731 write address).
- `i2c_ready` in 1: master accepts the request in any cycle where `i2c_req` && `i2c_ready`.
- `i2c_done` in 1: one-cycle pulse when the transfer finishes.
- `i2c_nack` in 1: valid only with `i2c_done`; 1 means the slave did not acknowledge.
- `audio_enable` out 1: high while the codec is configured.
- `busy` out 1: high in any state except DONE and FAIL.
- `done` out 1: high in DONE.
- `error` out 1: high in FAIL.
- `index` out 4: table entry currently being written.
- `retry_count` out 2: failures so far on the current entry.

## Operation
- Table entries 0..10: 16'h1E00 (reset), 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201 (activate).
- States: WAIT_PWR, ISSUE, WAIT_DONE, GAP, DONE, FAIL.
- WAIT_PWR: a counter runs from 0; at STARTUP_DELAY-1 the block moves to ISSUE.
- ISSUE: drives `i2c_req`=1 and `i2c_word`=table[index].
  - On the accept cycle, the next cycle has `i2c_req`=0, state WAIT_DONE, and the timeout counter cleared.
  - `i2c_word` holds its value until the next ISSUE.
- WAIT_DONE, success (`i2c_done` && !`i2c_nack`): `retry_count`←0.
  - If index==10, go to DONE.
  - Otherwise `index`++ and go to ISSUE.
- WAIT_DONE, failure (`i2c_done` && `i2c_nack`, or timeout counter reaches TIMEOUT-1 with no done):
  - If `retry_count`==MAX_RETRY, go to FAIL.
  - Otherwise `retry_count`++ and go to GAP.
- GAP: waits RETRY_GAP cycles, then returns to ISSUE with the same index.
- DONE: `audio_enable`=1 and `done`=1.
- FAIL: `error`=1 and `audio_enable`=0. `index` and `retry_count` freeze so the failing entry can be read.
- `start` in DONE or FAIL:
  - Clears `audio_enable`, `done` and `error`, and sets `index`←0 and `retry_count`←0.
  - Goes straight to ISSUE with no startup delay.
  - `start` in any other state is ignored.
- Outside WAIT_DONE, `i2c_done` and `i2c_nack` are ignored.
- Simultaneous `i2c_done` and timeout expiry in the same cycle: `i2c_done` and `i2c_nack` decide the outcome.

## Timing
- Every output is registered.
- Reset values: state WAIT_PWR, counter 0, `i2c_req` 0, `i2c_word` 16'h0000, `audio_enable` 0, `busy` 1, `done` 0, `error` 0, `index` 0, `retry_count` 0.
- Reset asserted mid-operation aborts any request in the same edge: `i2c_req` is 0 in the following cycle.
- First `i2c_req` rises STARTUP_DELAY cycles after the first cycle with reset low.
- Accept cycle to `i2c_req` low: 1 cycle.
- Success `i2c_done` to the next `i2c_req` high: 1 cycle.
- Failing `i2c_done` to the retry `i2c_req` high: RETRY_GAP+1 cycles.
- Final success `i2c_done` to `audio_enable` high: 1 cycle.
- `start` to `i2c_req` high: 1 cycle.

## Test plan
Bench parameters: STARTUP_DELAY=16, RETRY_GAP=4, MAX_RETRY=2, TIMEOUT=64. The I2C master model asserts `i2c_ready` at once and pulses `i2c_done` 10 cycles after accept.

1. Normal bring-up: release reset.
   - First `i2c_req` with `i2c_word`=16'h1E00 appears 16 cycles after release.
   - All 11 words appear in table order.
   - `audio_enable`=1 one cycle after the 11th done, with `busy`=0 and `done`=1.
2. Single NACK on entry 3: `i2c_word` 16'h0217 is re-issued 5 cycles after the NACK, then `retry_count` returns to 0 and the sequence completes normally.
3. Persistent NACK on entry 5: after 3 failures, `error`=1, `index`=5, `retry_count`=2, `audio_enable`=0, and `i2c_req` stays low.
4. Timeout: the model withholds `i2c_done` on entry 0.
   - The failure is taken 64 cycles after accept.
   - The retry `i2c_req` follows 5 cycles later.
   - A done arriving exactly on the 64th cycle with `i2c_nack`=0 counts as success.
5. Ready back-pressure: `i2c_ready` held low for 7 cycles. `i2c_req` and `i2c_word` stay stable throughout, and `i2c_req` drops 1 cycle after `i2c_ready` rises.
6. Reset during entry 4 of WAIT_DONE, then `start` from DONE:
   - The reset gives all reset values and a full re-run that starts with 16'h1E00 after 16 cycles.
   - `start` from DONE drops `audio_enable` and re-issues 16'h1E00 one cycle later.
   - `start` pulsed while `busy`=1 has no effect.

Source files
------------

// File: rtl/codec_init_sequencer.sv
// WM8731 power-up sequencer: walks the codec register table through an I2C
// write master, retries failed transfers, then releases the audio interface.
module codec_init_sequencer #(
    parameter int STARTUP_DELAY = 1024,
    parameter int RETRY_GAP     = 256,
    parameter int MAX_RETRY     = 3,
    parameter int TIMEOUT       = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [15:0] i2c_word,
    output logic [7:0]  i2c_dev_addr,
    input  logic        i2c_ready,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        audio_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  index,
    output logic [1:0]  retry_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_WAIT_PWR  = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int CNT_MAX_A = (STARTUP_DELAY > TIMEOUT) ? STARTUP_DELAY : TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > RETRY_GAP) ? CNT_MAX_A : RETRY_GAP;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RETRY_GAP - 1);
    localparam logic [3:0]       LAST_INDEX  = 4'd10;
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0C10;
            4'd2:    w = 16'h0017;
            4'd3:    w = 16'h0217;
            4'd4:    w = 16'h0479;
            4'd5:    w = 16'h0679;
            4'd6:    w = 16'h0812;
            4'd7:    w = 16'h0A00;
            4'd8:    w = 16'h0E02;
            4'd9:    w = 16'h1000;
            4'd10:   w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       index_q, index_d;
    logic [1:0]       retry_q, retry_d;
    logic             req_q, req_d;
    logic [15:0]      word_q, word_d;
    logic             audio_q, audio_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic accept;
    logic xfer_ok;
    logic xfer_fail;
    logic counting;

    // Handshake: a word is transferred on every rising clk edge where
    // i2c_req and i2c_ready are both high; i2c_req and i2c_word stay fixed
    // until then, and i2c_done/i2c_nack are only looked at in WAIT_DONE.
    assign accept = req_q && i2c_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT_PWR;
            cnt_q   <= '0;
            index_q <= '0;
            retry_q <= '0;
            req_q   <= 1'b0;
            word_q  <= 16'h0000;
            audio_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            word_q  <= word_d;
            audio_q <= audio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        retry_d   = retry_q;
        xfer_ok   = 1'b0;
        xfer_fail = 1'b0;

        case (state_q)
            ST_WAIT_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A done pulse wins over a timeout landing in the same cycle.
                if (i2c_done) begin
                    xfer_ok   = !i2c_nack;
                    xfer_fail = i2c_nack;
                end else begin
                    xfer_fail = (cnt_q == TO_LAST);
                end

                if (xfer_ok) begin
                    retry_d = '0;
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else if (xfer_fail) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    index_d = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_PWR;
            end
        endcase

        // One shared counter, restarted from zero on every state change.
        counting = (state_d == ST_WAIT_PWR) || (state_d == ST_WAIT_DONE) ||
                   (state_d == ST_GAP);
        cnt_d    = (counting && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;

        req_d   = (state_d == ST_ISSUE);
        word_d  = req_d ? table_word(index_d) : word_q;
        audio_d = (state_d == ST_DONE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_FAIL);
        busy_d  = (state_d != ST_DONE) && (state_d != ST_FAIL);
    end

    assign i2c_req      = req_q;
    assign i2c_word     = word_q;
    assign i2c_dev_addr = 8'h34;
    assign audio_enable = audio_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign index        = index_q;
    assign retry_count  = retry_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: an I2C master model follows a per-entry
// fault plan; expected words, entry, retry and timing come from a transfer-level model.
module tb_codec_init_sequencer;

    localparam int STARTUP_DELAY = 16;
    localparam int RETRY_GAP     = 4;
    localparam int MAX_RETRY     = 2;
    localparam int TIMEOUT       = 64;
    localparam int DONE_LAT      = 10;
    localparam int N_ENTRIES     = 11;

    localparam int K_OK      = 0;
    localparam int K_NACK    = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_LATE    = 3;

    typedef struct {
        int idx;
        int rc;
        int kind;
        int hold;
        int term;
    } att_t;

    typedef enum {P_WAIT_REQ, P_HOLD, P_ACCEPTED, P_WAIT_DONE, P_FINAL, P_END} phase_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic i2c_ready = 1'b1;
    logic i2c_done = 1'b0;
    logic i2c_nack = 1'b0;

    logic        i2c_req;
    logic [15:0] i2c_word;
    logic [7:0]  i2c_dev_addr;
    logic        audio_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  index;
    logic [1:0]  retry_count;
    logic [2:0]  state_dbg;

    int cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    codec_init_sequencer #(
        .STARTUP_DELAY(STARTUP_DELAY),
        .RETRY_GAP    (RETRY_GAP),
        .MAX_RETRY    (MAX_RETRY),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .i2c_req     (i2c_req),
        .i2c_word    (i2c_word),
        .i2c_dev_addr(i2c_dev_addr),
        .i2c_ready   (i2c_ready),
        .i2c_done    (i2c_done),
        .i2c_nack    (i2c_nack),
        .audio_enable(audio_enable),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .index       (index),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] tbl [N_ENTRIES] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217,
                                     16'h0479, 16'h0679, 16'h0812, 16'h0A00,
                                     16'h0E02, 16'h1000, 16'h1201};

    int fails [N_ENTRIES];
    int fkind [N_ENTRIES];
    bit late  [N_ENTRIES];
    int hold  [N_ENTRIES];

    logic [15:0] exp_q [$];
    att_t        att_q [$];
    bit          exp_fail;
    int          exp_fail_idx;
    int          exp_fail_rc;

    int n_checks = 0;
    int n_fail = 0;

    bit          mon_en = 1'b0;
    bit          scen_done = 1'b0;
    phase_t      phase = P_END;
    att_t        cur;
    logic [15:0] cur_w;
    int          hold_left;
    int          acc_cyc;
    int          done_cyc;
    int          exp_rise_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic clear_plan();
        for (int e = 0; e < N_ENTRIES; e++) begin
            fails[e] = 0;
            fkind[e] = K_NACK;
            late[e]  = 1'b0;
            hold[e]  = 0;
        end
    endtask

    task automatic random_plan();
        int r;
        clear_plan();
        for (int e = 0; e < N_ENTRIES; e++) begin
            r = $urandom_range(0, 19);
            if (r == 19) fails[e] = MAX_RETRY + 1;
            else if (r >= 14) fails[e] = $urandom_range(1, MAX_RETRY);
            fkind[e] = ($urandom_range(0, 3) == 0) ? K_TIMEOUT : K_NACK;
            late[e]  = ($urandom_range(0, 5) == 0);
            hold[e]  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
        end
    endtask

    // Each entry is attempted until it succeeds or has failed MAX_RETRY+1 times.
    task automatic build_model();
        att_t a;
        int   tries;
        exp_q.delete();
        att_q.delete();
        exp_fail = 1'b0;
        exp_fail_idx = 0;
        exp_fail_rc = 0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            tries = (fails[e] > MAX_RETRY) ? MAX_RETRY + 1 : fails[e];
            for (int t = 0; t < tries; t++) begin
                a.idx  = e;
                a.rc   = t;
                a.kind = fkind[e];
                a.hold = (t == 0) ? hold[e] : 0;
                a.term = (fails[e] > MAX_RETRY && t == tries - 1) ? 2 : 0;
                exp_q.push_back(tbl[e]);
                att_q.push_back(a);
            end
            if (fails[e] > MAX_RETRY) begin
                exp_fail = 1'b1;
                exp_fail_idx = e;
                exp_fail_rc = MAX_RETRY;
                break;
            end
            a.idx  = e;
            a.rc   = tries;
            a.kind = late[e] ? K_LATE : K_OK;
            a.hold = (tries == 0) ? hold[e] : 0;
            a.term = (e == N_ENTRIES - 1) ? 1 : 0;
            exp_q.push_back(tbl[e]);
            att_q.push_back(a);
        end
    endtask

    // ---------------- I2C master model / monitor ----------------
    initial begin
        bit ok;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (!mon_en) begin
                i2c_ready = 1'b1;
            end else begin
                case (phase)
                    P_WAIT_REQ: begin
                        if (i2c_req) begin
                            check_eq("req_time", cyc, exp_rise_cyc);
                            if (att_q.size() == 0) begin
                                check_eq("extra_req", i2c_req, 1'b0);
                                phase = P_END;
                                scen_done = 1'b1;
                            end else begin
                                cur   = att_q.pop_front();
                                cur_w = exp_q.pop_front();
                                check_eq("word", i2c_word, cur_w);
                                check_eq("index", index, cur.idx);
                                check_eq("retry_count", retry_count, cur.rc);
                                check_eq("busy_issue", busy, 1'b1);
                                check_eq("dev_addr", i2c_dev_addr, 8'h34);
                                if (cur.hold == 0) begin
                                    i2c_ready = 1'b1;
                                    acc_cyc = cyc;
                                    phase = P_ACCEPTED;
                                end else begin
                                    i2c_ready = 1'b0;
                                    hold_left = cur.hold;
                                    phase = P_HOLD;
                                end
                            end
                        end else if (cyc > exp_rise_cyc) begin
                            check_eq("req_missing", i2c_req, 1'b1);
                            phase = P_END;
                            scen_done = 1'b1;
                        end
                    end
                    P_HOLD: begin
                        check_eq("hold_req", i2c_req, 1'b1);
                        check_eq("hold_word", i2c_word, cur_w);
                        hold_left--;
                        if (hold_left == 0) begin
                            i2c_ready = 1'b1;
                            acc_cyc = cyc;
                            phase = P_ACCEPTED;
                        end
                    end
                    P_ACCEPTED: begin
                        check_eq("req_drop", i2c_req, 1'b0);
                        done_cyc = (cur.kind == K_OK || cur.kind == K_NACK) ?
                                   acc_cyc + DONE_LAT : acc_cyc + TIMEOUT;
                        phase = P_WAIT_DONE;
                    end
                    P_WAIT_DONE: begin
                        check_eq("req_quiet", i2c_req, 1'b0);
                        if (cyc == done_cyc) begin
                            ok = (cur.kind == K_OK || cur.kind == K_LATE);
                            if (cur.kind != K_TIMEOUT) begin
                                i2c_done = 1'b1;
                                i2c_nack = (cur.kind == K_NACK);
                            end
                            if (cur.term != 0) begin
                                phase = P_FINAL;
                            end else begin
                                exp_rise_cyc = ok ? cyc + 1 : cyc + RETRY_GAP + 1;
                                phase = P_WAIT_REQ;
                            end
                        end
                    end
                    P_FINAL: begin
                        check_eq("audio_enable", audio_enable, !exp_fail);
                        check_eq("done", done, !exp_fail);
                        check_eq("error", error, exp_fail);
                        check_eq("busy_end", busy, 1'b0);
                        if (exp_fail) begin
                            check_eq("fail_index", index, exp_fail_idx);
                            check_eq("fail_retry", retry_count, exp_fail_rc);
                        end
                        phase = P_END;
                        scen_done = 1'b1;
                    end
                    default: begin
                        i2c_ready = 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic arm(input int rise_cyc);
        scen_done = 1'b0;
        phase = P_WAIT_REQ;
        exp_rise_cyc = rise_cyc;
        mon_en = 1'b1;
    endtask

    task automatic check_reset_values();
        check_eq("rst_req", i2c_req, 1'b0);
        check_eq("rst_word", i2c_word, 16'h0000);
        check_eq("rst_audio", audio_enable, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_index", index, 4'd0);
        check_eq("rst_retry", retry_count, 2'd0);
    endtask

    task automatic start_run();
        start = 1'b1;
        arm(cyc + 1);
        step();
        start = 1'b0;
        check_eq("start_audio_off", audio_enable, 1'b0);
        check_eq("start_done_off", done, 1'b0);
        check_eq("start_error_off", error, 1'b0);
        check_eq("start_busy", busy, 1'b1);
    endtask

    task automatic wait_scen(input int budget);
        int n;
        n = 0;
        while (!scen_done && n < budget) begin
            step();
            n++;
        end
        check_eq("scenario_end", scen_done, 1'b1);
        mon_en = 1'b0;
        repeat (6) step();
        check_eq("req_idle", i2c_req, 1'b0);
        check_eq("queue_empty", att_q.size(), 0);
    endtask

    task automatic wait_entry(input int e);
        int n;
        n = 0;
        while (!(phase == P_WAIT_DONE && cur.idx == e) && n < 3000) begin
            step();
            n++;
        end
        check_eq("reach_entry", (phase == P_WAIT_DONE && cur.idx == e), 1'b1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1;
        repeat (3) step();
        check_reset_values();

        // Power-up bring-up with a clean table.
        clear_plan();
        build_model();
        reset = 1'b0;
        arm(cyc + STARTUP_DELAY);
        wait_scen(3000);

        // Single NACK on entry 3 plus ready back-pressure on entry 6.
        clear_plan();
        fails[3] = 1;
        fkind[3] = K_NACK;
        hold[6] = 7;
        build_model();
        start_run();
        wait_scen(3000);

        // Persistent NACK on entry 5 ends in FAIL.
        clear_plan();
        fails[5] = MAX_RETRY + 1;
        fkind[5] = K_NACK;
        build_model();
        start_run();
        wait_scen(3000);

        // Timeout on entry 0, then a done landing on the last timeout cycle.
        clear_plan();
        fails[0] = 1;
        fkind[0] = K_TIMEOUT;
        late[0] = 1'b1;
        build_model();
        start_run();
        wait_scen(3000);

        // Reset while entry 4 is in flight, then ignored start pulses while busy.
        clear_plan();
        build_model();
        start_run();
        wait_entry(4);
        mon_en = 1'b0;
        reset = 1'b1;
        step();
        check_reset_values();
        reset = 1'b0;
        clear_plan();
        build_model();
        arm(cyc + STARTUP_DELAY);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_entry(2);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_scen(3000);

        // Randomized fault plans.
        for (int r = 0; r < 8; r++) begin
            random_plan();
            build_model();
            start_run();
            wait_scen(6000);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
